// File: rtl/hazard_ctrl_pipe_if.sv
// ID-stage hazard query and EX forwarding/stall response bundle for hazard_ctrl_pipe.
interface hazard_ctrl_pipe_if #(
   parameter int unsigned AW   = 4,
   parameter int unsigned NSRC = 3,
   parameter int unsigned CW   = 16
);
   logic                 id_valid;
   logic [NSRC*AW-1:0]   id_src;
   logic [NSRC-1:0]      id_src_use;
   logic [AW-1:0]        id_rd;
   logic                 id_rd_we;
   logic                 id_is_load;
   logic                 flush;
   logic                 stall;
   logic                 bubble;
   logic [2*NSRC-1:0]    fwd_sel;
   logic [CW-1:0]        stall_cnt;

   modport master (
      output id_valid, id_src, id_src_use, id_rd, id_rd_we, id_is_load, flush,
      input  stall, bubble, fwd_sel, stall_cnt
   );

   modport slave (
      input  id_valid, id_src, id_src_use, id_rd, id_rd_we, id_is_load, flush,
      output stall, bubble, fwd_sel, stall_cnt
   );
endinterface

// File: rtl/hazard_ctrl_pipe.sv
// Hazard controller for the ARM32 5-stage pipe: shadow EX/MEM/WB destination
// tracking, registered EX forwarding selects, load-use stall and stall counter.
module hazard_ctrl_pipe #(
   parameter int unsigned NREG     = 16,
   parameter int unsigned AW       = 4,
   parameter int unsigned NSRC     = 3,
   parameter int unsigned LD_STALL = 1,
   parameter int unsigned PC_REG   = 15,
   parameter int unsigned CW       = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   hazard_ctrl_pipe_if.slave bus
);
   localparam int unsigned   FW      = 2 * NSRC;
   localparam int unsigned   KW      = 3;
   localparam logic [AW-1:0] PC_A    = AW'(PC_REG);
   localparam logic [KW-1:0] LD_M1   = KW'(LD_STALL - 1);
   localparam bit            MULTI   = (LD_STALL > 1);
   localparam logic [1:0]    SEL_MEM = 2'b01;
   localparam logic [1:0]    SEL_WB  = 2'b10;

   if ((2 ** AW) < NREG) begin : g_chk_aw
      $error("hazard_ctrl_pipe: AW too narrow for NREG");
   end
   if ((LD_STALL < 1) || (LD_STALL > 7)) begin : g_chk_ld
      $error("hazard_ctrl_pipe: LD_STALL must be 1..7");
   end

   typedef struct packed {
      logic          v;
      logic [AW-1:0] rd;
      logic          we;
      logic          ld;
   } stage_t;

   typedef enum logic {RUN, HOLD} state_t;

   stage_t         r_ex;
   stage_t         r_mem;
   stage_t         r_wb;
   state_t         r_state;
   logic [KW-1:0]  r_cnt;
   logic [FW-1:0]  r_fwd;
   logic [CW-1:0]  r_stall_cnt;

   logic            w_ex_def;
   logic            w_mem_def;
   logic [NSRC-1:0] w_hit_ex;
   logic [NSRC-1:0] w_hit_mem;
   logic            w_load_use;
   logic            w_stall;
   logic [FW-1:0]   w_fwd_nxt;
   stage_t          w_ex_nxt;
   logic            w_unused_wb;

   // A stage only defines a register if it really writes one other than the PC.
   assign w_ex_def  = r_ex.v  & r_ex.we  & (r_ex.rd  != PC_A);
   assign w_mem_def = r_mem.v & r_mem.we & (r_mem.rd != PC_A);

   always_comb begin
      w_hit_ex  = '0;
      w_hit_mem = '0;
      for (int unsigned k = 0; k < NSRC; k++) begin
         w_hit_ex[k]  = bus.id_valid & bus.id_src_use[k] & w_ex_def
                      & (bus.id_src[k*AW +: AW] == r_ex.rd)
                      & (bus.id_src[k*AW +: AW] != PC_A);
         w_hit_mem[k] = bus.id_valid & bus.id_src_use[k] & w_mem_def
                      & (bus.id_src[k*AW +: AW] == r_mem.rd)
                      & (bus.id_src[k*AW +: AW] != PC_A);
      end
   end

   assign w_load_use = (|w_hit_ex) & r_ex.ld;
   assign w_stall    = ~bus.flush & ((r_state == HOLD) | w_load_use);

   // Youngest producer wins; stall and flush both leave EX with a bubble.
   always_comb begin
      w_fwd_nxt = '0;
      if (!w_stall && !bus.flush) begin
         for (int unsigned k = 0; k < NSRC; k++) begin
            if (w_hit_ex[k] && !r_ex.ld) begin
               w_fwd_nxt[2*k +: 2] = SEL_MEM;
            end else if (w_hit_mem[k]) begin
               w_fwd_nxt[2*k +: 2] = SEL_WB;
            end
         end
      end
   end

   always_comb begin
      w_ex_nxt = '0;
      if (!w_stall && !bus.flush) begin
         w_ex_nxt.v  = bus.id_valid;
         w_ex_nxt.rd = bus.id_rd;
         w_ex_nxt.we = bus.id_rd_we;
         w_ex_nxt.ld = bus.id_is_load;
      end
   end

   // Older stages always advance, so a flush never kills MEM or WB.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_ex        <= '0;
         r_mem       <= '0;
         r_wb        <= '0;
         r_fwd       <= '0;
         r_stall_cnt <= '0;
      end else begin
         r_ex  <= w_ex_nxt;
         r_mem <= r_ex;
         r_wb  <= r_mem;
         r_fwd <= w_fwd_nxt;
         if (w_stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CW'(1);
         end
      end
   end

   // RUN covers the first stall cycle; HOLD covers the remaining LD_STALL-1.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= RUN;
         r_cnt   <= '0;
      end else if (bus.flush) begin
         r_state <= RUN;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            RUN: begin
               if (w_load_use) begin
                  r_cnt <= LD_M1;
                  if (MULTI) begin
                     r_state <= HOLD;
                  end
               end
            end
            HOLD: begin
               r_cnt <= r_cnt - KW'(1);
               if (r_cnt == KW'(1)) begin
                  r_state <= RUN;
               end
            end
            default: begin
               r_state <= RUN;
               r_cnt   <= '0;
            end
         endcase
      end
   end

   // The WB shadow is kept for visibility only; no select ever needs it.
   assign w_unused_wb = ^r_wb;

   assign bus.stall     = w_stall;
   assign bus.bubble    = w_stall;
   assign bus.fwd_sel   = r_fwd;
   assign bus.stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl_pipe.sv
// Scoreboard bench for hazard_ctrl_pipe: dut 0 uses LD_STALL=1/CW=16,
// dut 1 uses LD_STALL=3/CW=4 for multi-cycle stall and saturation cases.
module tb_hazard_ctrl_pipe;
   localparam int unsigned AW   = 4;
   localparam int unsigned NSRC = 3;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   hazard_ctrl_pipe_if #(.AW(AW), .NSRC(NSRC), .CW(16)) ifa ();
   hazard_ctrl_pipe_if #(.AW(AW), .NSRC(NSRC), .CW(4))  ifb ();

   hazard_ctrl_pipe #(.LD_STALL(1), .CW(16)) u_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
   hazard_ctrl_pipe #(.LD_STALL(3), .CW(4))  u_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));

   typedef struct {
      int          when;
      int          dut;
      int          kind;
      logic [31:0] val;
      string       name;
   } exp_t;

   exp_t  sb[$];
   int    total = 0;
   int    bad   = 0;
   int    cyc   = 0;
   int    mcnt[2] = '{0, 0};
   int    msat[2] = '{65535, 15};
   string tname = "reset";

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] actual(input int dut, input int kind);
      logic [31:0] r;
      r = '0;
      case (kind)
         0:       r = (dut == 0) ? {30'd0, ifa.stall, ifa.bubble} : {30'd0, ifb.stall, ifb.bubble};
         1:       r = (dut == 0) ? 32'(ifa.fwd_sel) : 32'(ifb.fwd_sel);
         default: r = (dut == 0) ? 32'(ifa.stall_cnt) : 32'(ifb.stall_cnt);
      endcase
      return r;
   endfunction

   function automatic string kname(input int kind);
      case (kind)
         0:       return "stall/bubble";
         1:       return "fwd_sel";
         default: return "stall_cnt";
      endcase
   endfunction

   // Monitor: every expectation due this cycle is popped and compared.
   always @(negedge clk) begin
      exp_t        keep[$];
      logic [31:0] a;
      keep = {};
      foreach (sb[i]) begin
         if (sb[i].when == cyc) begin
            a = actual(sb[i].dut, sb[i].kind);
            total++;
            if (a !== sb[i].val) begin
               bad++;
               $display("FAIL %s dut%0d %s: got 0x%0h want 0x%0h (cycle %0d)",
                        sb[i].name, sb[i].dut, kname(sb[i].kind), a, sb[i].val, cyc);
            end
         end else if (sb[i].when < cyc) begin
            total++;
            bad++;
            $display("FAIL %s dut%0d %s: never sampled, want 0x%0h", sb[i].name,
                     sb[i].dut, kname(sb[i].kind), sb[i].val);
         end else begin
            keep.push_back(sb[i]);
         end
      end
      sb = keep;
   end

   task automatic push(input int off, input int dut, input int kind, input logic [31:0] v);
      exp_t e;
      e.when = cyc + off;
      e.dut  = dut;
      e.kind = kind;
      e.val  = v;
      e.name = tname;
      sb.push_back(e);
   endtask

   // Expect stall state now, and the stall count accumulated before this cycle.
   task automatic chk(input int dut, input bit s);
      push(0, dut, 0, {30'd0, s, s});
      push(0, dut, 2, 32'(mcnt[dut]));
      if (s && (mcnt[dut] < msat[dut])) mcnt[dut]++;
   endtask

   // Expect the select that this cycle's ID instruction carries into EX.
   task automatic chkf(input int dut, input logic [5:0] f);
      push(1, dut, 1, 32'(f));
   endtask

   task automatic drive_idle();
      ifa.id_valid = 1'b0; ifa.id_src = '0; ifa.id_src_use = '0; ifa.id_rd = '0;
      ifa.id_rd_we = 1'b0; ifa.id_is_load = 1'b0; ifa.flush = 1'b0;
      ifb.id_valid = 1'b0; ifb.id_src = '0; ifb.id_src_use = '0; ifb.id_rd = '0;
      ifb.id_rd_we = 1'b0; ifb.id_is_load = 1'b0; ifb.flush = 1'b0;
   endtask

   task automatic ins(input int dut, input bit v, input logic [3:0] s0, input logic [3:0] s1,
                      input logic [3:0] s2, input logic [2:0] u, input logic [3:0] rd,
                      input bit we, input bit ld, input bit fl);
      @(posedge clk);
      #1;
      drive_idle();
      if (dut == 0) begin
         ifa.id_valid = v; ifa.id_src = {s2, s1, s0}; ifa.id_src_use = u; ifa.id_rd = rd;
         ifa.id_rd_we = we; ifa.id_is_load = ld; ifa.flush = fl;
      end else begin
         ifb.id_valid = v; ifb.id_src = {s2, s1, s0}; ifb.id_src_use = u; ifb.id_rd = rd;
         ifb.id_rd_we = we; ifb.id_is_load = ld; ifb.flush = fl;
      end
   endtask

   task automatic nop(input int dut);
      ins(dut, 1'b0, 4'd0, 4'd0, 4'd0, 3'b000, 4'd0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic alu(input int dut, input logic [3:0] rd, input logic [3:0] s0,
                      input logic [3:0] s1, input bit fl);
      ins(dut, 1'b1, s0, s1, 4'd0, 3'b011, rd, 1'b1, 1'b0, fl);
   endtask

   task automatic ldr(input int dut, input logic [3:0] rd, input logic [3:0] base);
      ins(dut, 1'b1, base, 4'd0, 4'd0, 3'b001, rd, 1'b1, 1'b1, 1'b0);
   endtask

   // LDR R1,[R4] then ADD R2,R3,R1 held through a 3-cycle stall on dut 1.
   task automatic ld_use_b();
      ldr(1, 4'd1, 4'd4); chk(1, 1'b0);
      repeat (3) begin
         alu(1, 4'd2, 4'd3, 4'd1, 1'b0); chk(1, 1'b1);
      end
      alu(1, 4'd2, 4'd3, 4'd1, 1'b0); chk(1, 1'b0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not end");
      $fatal(1, "watchdog");
   end

   initial begin
      drive_idle();
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      tname = "reset";
      chk(0, 1'b0); chk(1, 1'b0);
      push(0, 0, 1, 32'd0); push(0, 1, 1, 32'd0);

      tname = "fwd_ex";
      alu(0, 4'd1, 4'd2, 4'd3, 1'b0); chk(0, 1'b0);
      alu(0, 4'd4, 4'd1, 4'd2, 1'b0); chk(0, 1'b0); chkf(0, 6'b000001);
      nop(0);                         chk(0, 1'b0);

      tname = "fwd_wb";
      alu(0, 4'd1, 4'd2, 4'd3, 1'b0); chk(0, 1'b0);
      nop(0);                         chk(0, 1'b0);
      alu(0, 4'd5, 4'd6, 4'd1, 1'b0); chk(0, 1'b0); chkf(0, 6'b001000);

      tname = "youngest";
      alu(0, 4'd1, 4'd2, 4'd3, 1'b0); chk(0, 1'b0);
      alu(0, 4'd1, 4'd2, 4'd3, 1'b0); chk(0, 1'b0);
      alu(0, 4'd7, 4'd1, 4'd1, 1'b0); chk(0, 1'b0); chkf(0, 6'b000101);

      tname = "load_use1";
      ldr(0, 4'd1, 4'd4);             chk(0, 1'b0);
      alu(0, 4'd2, 4'd3, 4'd1, 1'b0); chk(0, 1'b1);
      alu(0, 4'd2, 4'd3, 4'd1, 1'b0); chk(0, 1'b0); push(0, 0, 1, 32'd0); chkf(0, 6'b001000);

      tname = "pc_excl";
      alu(0, 4'd15, 4'd1, 4'd2, 1'b0);                                  chk(0, 1'b0);
      ins(0, 1'b1, 4'd15, 4'd0, 4'd0, 3'b001, 4'd3, 1'b1, 1'b0, 1'b0); chk(0, 1'b0); chkf(0, 6'b000000);
      ldr(0, 4'd15, 4'd1);                                              chk(0, 1'b0);
      alu(0, 4'd5, 4'd15, 4'd0, 1'b0);                                  chk(0, 1'b0); chkf(0, 6'b000000);

      tname = "no_write";
      ins(0, 1'b1, 4'd1, 4'd2, 4'd0, 3'b011, 4'd0, 1'b0, 1'b0, 1'b0);  chk(0, 1'b0);
      alu(0, 4'd1, 4'd0, 4'd2, 1'b0);                                   chk(0, 1'b0); chkf(0, 6'b000000);

      tname = "flush_fwd";
      alu(0, 4'd1, 4'd2, 4'd3, 1'b0); chk(0, 1'b0);
      alu(0, 4'd4, 4'd1, 4'd2, 1'b1); chk(0, 1'b0); chkf(0, 6'b000000);
      alu(0, 4'd4, 4'd1, 4'd2, 1'b0); chk(0, 1'b0); chkf(0, 6'b000010);

      tname = "flush_ld";
      ldr(0, 4'd1, 4'd4);             chk(0, 1'b0);
      alu(0, 4'd2, 4'd3, 4'd1, 1'b1); chk(0, 1'b0); chkf(0, 6'b000000);
      nop(0);                         chk(0, 1'b0);

      tname = "ld3_sat";
      for (int i = 0; i < 7; i++) ld_use_b();

      tname = "flush_hold";
      ldr(1, 4'd1, 4'd4);             chk(1, 1'b0);
      alu(1, 4'd2, 4'd3, 4'd1, 1'b0); chk(1, 1'b1);
      alu(1, 4'd2, 4'd3, 4'd1, 1'b1); chk(1, 1'b0);
      alu(1, 4'd2, 4'd3, 4'd1, 1'b0); chk(1, 1'b0); push(0, 1, 1, 32'd0); chkf(1, 6'b000000);

      tname = "ld3_again";
      ld_use_b();

      tname = "rst_hold";
      ldr(1, 4'd1, 4'd4);             chk(1, 1'b0);
      alu(1, 4'd2, 4'd3, 4'd1, 1'b0); chk(1, 1'b1);
      alu(1, 4'd2, 4'd3, 4'd1, 1'b0); chk(1, 1'b1);
      rst_n = 1'b0;
      alu(1, 4'd2, 4'd3, 4'd1, 1'b0);
      rst_n = 1'b1;
      mcnt[0] = 0;
      mcnt[1] = 0;
      chk(1, 1'b0); chk(0, 1'b0); push(0, 1, 1, 32'd0);
      alu(1, 4'd2, 4'd3, 4'd1, 1'b0); chk(1, 1'b0);
      nop(1);                         chk(1, 1'b0);

      repeat (3) @(posedge clk);
      #1;
      if (sb.size() != 0) begin
         $display("FAIL scoreboard: %0d expectations left unchecked", sb.size());
         total += sb.size();
         bad   += sb.size();
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
